divider_unit: RTL and testbench
===============================

# divider_unit

Multi-cycle 32-bit integer divider for the MIPS datapath, executing DIV and DIVU by restoring shift-and-subtract, one quotient bit per cycle. It is the subtractive counterpart to the single-cycle adder on the execute path. It sits beside the ALU and feeds the HI register (remainder) and LO register (quotient). Control launches it with a start/busy/done handshake and stalls the pipeline while it runs.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  launch request; sampled only while busy=0
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  32  numerator, captured on accepted start
- divisor  input  32  denominator, captured on accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse: quotient/remainder/div_by_zero are valid and updated
- quotient  output  32  LO result, held until next done
- remainder  output  32  HI result, held until next done
- div_by_zero  output  1  set with done when divisor was 0, held until next done

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 accepts the operation and latches is_signed and the operands; divisor≠0 -> CALC with count=0, busy=1; divisor=0 -> FIX directly.
- Setup at accept (signed mode): take magnitudes of operands; record q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend). Unsigned mode: q_neg=r_neg=0.
- CALC: 33-bit partial remainder. Each cycle shift {rem, quo} left one bit, trial-subtract the divisor magnitude, keep on non-negative, set quo LSB accordingly; count increments 0..31; leaves to FIX after count=31 (32 CALC cycles).
- FIX: negate quotient if q_neg, negate remainder if r_neg (32-bit two's complement, wrap allowed); register outputs; pulse done; busy=0; -> IDLE.
- Divide by zero: quotient=32'hFFFFFFFF, remainder=dividend as given (unmodified), div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (natural wrap); div_by_zero=0.
- Remainder sign always follows the dividend (truncating division); |remainder| < |divisor|.
- start while busy=1: ignored, no effect on the operation in flight.
- Operand/is_signed changes while busy: ignored.

## Timing
- Accepting edge = E0. Normal path: busy=1 after E0; CALC spans E1..E32; FIX at E33; done=1 and new results visible after E33 and for one cycle only; busy=0 after E33. Latency 33 cycles.
- Divide-by-zero path: FIX at E1; done after E1; latency 1 cycle.
- done and busy are never high together.
- start in the cycle where done=1 (state IDLE) is accepted; back-to-back throughput 34 cycles.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- Reset asserted mid-operation: aborts immediately (asynchronous); no done pulse; outputs return to reset values; the first start after release behaves normally.

## Test plan
- DIVU 100 / 7, start one cycle -> busy for 33 cycles, done pulse after E33, quotient=14, remainder=2, div_by_zero=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divisor 0 with dividend 0x12345678 -> done after 1 cycle, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x12345678; the next valid divide clears div_by_zero.
- Start 50/5, re-assert start with 9/3 at cycle 10 and change operands -> result still 10 r 0 at E33; start held high on the done cycle launches a new op.
- Reset at cycle 15 of a divide -> busy=0 and outputs 0 immediately, no done pulse; subsequent DIVU 81/9 -> quotient 9, remainder 0 at 33 cycles.

Source files
------------

// File: rtl/divider_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the MIPS HI/LO path.
// One quotient bit per cycle; sign fix-up and divide-by-zero handling in a final FIX cycle.
module divider_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, quo_q, dvs_q, dvd_q;
    logic [4:0]  count_q;
    logic        q_neg_q, r_neg_q, dbz_q;

    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, diff;
    logic [31:0] rem_next, quo_next;

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

    assign mag_a = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign mag_b = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // Trial subtraction on the 33-bit shifted partial remainder; bit 32 of diff is the borrow.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        rem_next = shifted[31:0];
        quo_next = {quo_q[30:0], 1'b0};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (divisor == 32'd0) ? FIX : CALC;
            CALC:    if (count_q == 5'd31) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            dvd_q       <= 32'd0;
            count_q     <= 5'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            done        <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_neg_q <= is_signed & (dividend[31] ^ divisor[31]);
                        r_neg_q <= is_signed & dividend[31];
                        dvs_q   <= mag_b;
                        quo_q   <= mag_a;
                        rem_q   <= 32'd0;
                        count_q <= 5'd0;
                        dvd_q   <= dividend;
                        dbz_q   <= (divisor == 32'd0);
                    end
                end
                CALC: begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    count_q <= count_q + 5'd1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dbz_q;
                    if (dbz_q) begin
                        // Divide by zero reports the raw dividend as remainder, all-ones quotient.
                        quotient  <= 32'hFFFF_FFFF;
                        remainder <= dvd_q;
                    end else begin
                        quotient  <= q_neg_q ? (~quo_q + 32'd1) : quo_q;
                        remainder <= r_neg_q ? (~rem_q + 32'd1) : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed DIV/DIVU vectors, start-ignore,
// back-to-back launch on done, and asynchronous reset abort.
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    logic [1:0]  fsm_state;

    int unsigned cyc = 0;
    int          tests = 0;
    int          failed = 0;

    // Entry layout: {done_cycle[31:0], quotient, remainder, div_by_zero}
    logic [96:0] exp_q[$];

    divider_unit dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        logic [96:0] e;
        if (!reset) begin
            if (done && busy) check("done_and_busy", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", quotient, e[64:33]);
                    check("remainder", remainder, e[32:1]);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
                    check("done_cycle", cyc, e[96:65]);
                end
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start released.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ed,
                         output logic [31:0] at);
        at = cyc + ((b == 32'd0) ? 32'd2 : 32'd34);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        exp_q.push_back({at, eq, er, ed});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ed);
        logic [31:0] at;
        issue(s, a, b, eq, er, ed, at);
        wait_idle();
    endtask

    initial begin
        logic [31:0] at1;
        int cnt, k;

        #23;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // DIVU 100/7 with busy-duration check
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, at1);
        cnt = 0;
        k = 0;
        while (!done && k < 60) begin
            if (busy) cnt++;
            @(negedge clk);
            k++;
        end
        check("busy_cycles", cnt, 32'd33);
        wait_idle();

        run(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0);
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0);
        run(1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run(1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        run(1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0);

        // Start re-asserted mid-operation is ignored; held through done it launches the next op.
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, at1);
        repeat (9) @(negedge clk);
        is_signed = 1'b1;
        dividend  = 32'd9;
        divisor   = 32'd3;
        start     = 1'b1;
        exp_q.push_back({at1 + 32'd34, 32'd3, 32'd0, 1'b0});
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_wait", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, at1);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        check("abort_state", {30'd0, fsm_state}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run(1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
